tdm_frame_collector: RTL and testbench

Upstream front end of the DSP core. Deserializes an 8-slot TDM audio stream from the external ADC pins, converts each 24-bit sample to the core's 36-bit fixed-point word, and presents all channels as a parallel frame on `inputs`. Issues the one-cycle `start` strobe that begins one sample period of program execution in the core.

---
 rtl/tdm_frame_collector.sv | 143 ++++++++++++++
 tb/tb_tdm_frame_collector.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tdm_frame_collector.sv
// TDM audio front end: deserializes an N_CH-slot TDM stream from raw pins, widens each
// sample to the core's fixed-point word and publishes one parallel frame per sample period.
module tdm_frame_collector #(
    parameter int N_CH        = 8,
    parameter int SLOT_BITS   = 32,
    parameter int SAMPLE_BITS = 24,
    parameter int WORD_W      = 36,
    parameter int FRAC_SHIFT  = 10
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              sclk_in,
    input  logic              fs_in,
    input  logic              sd_in,
    output logic [WORD_W-1:0] inputs [N_CH],
    output logic              start,
    output logic              frame_err
);

    localparam int BIT_CW  = $clog2(SLOT_BITS);
    localparam int SLOT_CW = $clog2(N_CH);
    localparam logic [BIT_CW-1:0]  LAST_BIT   = BIT_CW'(SLOT_BITS - 1);
    localparam logic [BIT_CW-1:0]  SAMPLE_END = BIT_CW'(SAMPLE_BITS);
    localparam logic [SLOT_CW-1:0] LAST_SLOT  = SLOT_CW'(N_CH - 1);

    typedef enum logic [1:0] {IDLE, COLLECT, PUBLISH} state_e;

    state_e                 state_q, state_d;
    logic [2:0]             sclk_sync_q;
    logic [1:0]             fs_sync_q, sd_sync_q;
    logic                   fs_prev_q, fs_prev_d;
    logic [BIT_CW-1:0]      bit_cnt_q, bit_cnt_d;
    logic [SLOT_CW-1:0]     slot_cnt_q, slot_cnt_d;
    logic [SAMPLE_BITS-1:0] shift_q, shift_d;
    logic [SAMPLE_BITS-1:0] shadow_q [N_CH];
    logic [SAMPLE_BITS-1:0] shadow_d [N_CH];
    logic [WORD_W-1:0]      inputs_q [N_CH];
    logic [WORD_W-1:0]      inputs_d [N_CH];
    logic                   start_q, start_d;
    logic                   frame_err_q, frame_err_d;

    logic sclk_rise, fs_s, sd_s, marker;

    // Bit 2 of the sclk chain is the edge-detect stage; fs/sd are taken from the same depth.
    assign sclk_rise = sclk_sync_q[1] & ~sclk_sync_q[2];
    assign fs_s      = fs_sync_q[1];
    assign sd_s      = sd_sync_q[1];
    assign marker    = sclk_rise & fs_s & ~fs_prev_q;

    function automatic logic [WORD_W-1:0] to_word(input logic [SAMPLE_BITS-1:0] s);
        return {{(WORD_W - SAMPLE_BITS - FRAC_SHIFT){s[SAMPLE_BITS-1]}}, s, {FRAC_SHIFT{1'b0}}};
    endfunction

    always_comb begin
        // NOTE: every _d gets a default before the case so no path leaves it unassigned (no latches).
        state_d     = state_q;
        fs_prev_d   = fs_prev_q;
        bit_cnt_d   = bit_cnt_q;
        slot_cnt_d  = slot_cnt_q;
        shift_d     = shift_q;
        shadow_d    = shadow_q;
        inputs_d    = inputs_q;
        start_d     = 1'b0;
        frame_err_d = 1'b0;

        if (sclk_rise) fs_prev_d = fs_s;

        case (state_q)
            IDLE: begin
                if (marker) begin
                    shift_d    = {shift_q[SAMPLE_BITS-2:0], sd_s};
                    bit_cnt_d  = BIT_CW'(1);
                    slot_cnt_d = '0;
                    state_d    = COLLECT;
                end
            end
            COLLECT: begin
                if (marker) begin
                    // Marker mid-frame: drop the partial frame and resync on this bit.
                    frame_err_d = 1'b1;
                    shift_d     = {shift_q[SAMPLE_BITS-2:0], sd_s};
                    bit_cnt_d   = BIT_CW'(1);
                    slot_cnt_d  = '0;
                end else if (sclk_rise) begin
                    if (bit_cnt_q < SAMPLE_END) shift_d = {shift_q[SAMPLE_BITS-2:0], sd_s};
                    if (bit_cnt_q == LAST_BIT) begin
                        shadow_d[slot_cnt_q] = shift_d;
                        bit_cnt_d            = '0;
                        slot_cnt_d           = slot_cnt_q + SLOT_CW'(1);
                        if (slot_cnt_q == LAST_SLOT) state_d = PUBLISH;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BIT_CW'(1);
                    end
                end
            end
            PUBLISH: begin
                for (int k = 0; k < N_CH; k++) inputs_d[k] = to_word(shadow_q[k]);
                start_d = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sclk_sync_q <= '0;
            fs_sync_q   <= '0;
            sd_sync_q   <= '0;
            state_q     <= IDLE;
            fs_prev_q   <= 1'b0;
            bit_cnt_q   <= '0;
            slot_cnt_q  <= '0;
            shift_q     <= '0;
            start_q     <= 1'b0;
            frame_err_q <= 1'b0;
            // NOTE: shadow and output words are reset explicitly, so they are flops, not RAM.
            for (int k = 0; k < N_CH; k++) begin
                shadow_q[k] <= '0;
                inputs_q[k] <= '0;
            end
        end else begin
            // NOTE: non-blocking everywhere here so all registers update from pre-edge values.
            sclk_sync_q <= {sclk_sync_q[1:0], sclk_in};
            fs_sync_q   <= {fs_sync_q[0], fs_in};
            sd_sync_q   <= {sd_sync_q[0], sd_in};
            state_q     <= state_d;
            fs_prev_q   <= fs_prev_d;
            bit_cnt_q   <= bit_cnt_d;
            slot_cnt_q  <= slot_cnt_d;
            shift_q     <= shift_d;
            shadow_q    <= shadow_d;
            inputs_q    <= inputs_d;
            start_q     <= start_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign inputs    = inputs_q;
    assign start     = start_q;
    assign frame_err = frame_err_q;

endmodule

// File: tb/tb_tdm_frame_collector.sv
// Randomized bench for tdm_frame_collector: drives bit streams on the pins and compares
// published frames, error pulses and timing against a frame-level reference model.
module tb_tdm_frame_collector;

    localparam int N_CH        = 8;
    localparam int SLOT_BITS   = 32;
    localparam int SAMPLE_BITS = 24;
    localparam int WORD_W      = 36;
    localparam int FRAC_SHIFT  = 10;
    localparam int FRAME_BITS  = N_CH * SLOT_BITS;
    localparam int BIT_CLKS    = 8;

    typedef logic [N_CH-1:0][WORD_W-1:0]      frame_t;
    typedef logic [N_CH-1:0][SAMPLE_BITS-1:0] samples_t;

    logic              clk;
    logic              reset_n;
    logic              sclk_in, fs_in, sd_in;
    logic [WORD_W-1:0] inputs [N_CH];
    logic              start, frame_err;

    tdm_frame_collector #(
        .N_CH(N_CH), .SLOT_BITS(SLOT_BITS), .SAMPLE_BITS(SAMPLE_BITS),
        .WORD_W(WORD_W), .FRAC_SHIFT(FRAC_SHIFT)
    ) dut (
        .clk(clk), .reset_n(reset_n), .sclk_in(sclk_in), .fs_in(fs_in), .sd_in(sd_in),
        .inputs(inputs), .start(start), .frame_err(frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic frame_t pack_inputs();
        frame_t f;
        for (int k = 0; k < N_CH; k++) f[k] = inputs[k];
        return f;
    endfunction

    // Monitor: records every publication and counts anything that breaks output hold.
    frame_t      pub_q[$];
    int unsigned pubcyc_q[$];
    int          err_cnt = 0;
    int          viol    = 0;
    frame_t      last_frame;
    logic        prev_start;

    always @(negedge clk) begin
        if (!reset_n) begin
            last_frame = '0;
            prev_start = 1'b0;
        end else begin
            if (start) begin
                pub_q.push_back(pack_inputs());
                pubcyc_q.push_back(cyc);
                if (prev_start) viol++;
            end else if (pack_inputs() != last_frame) begin
                viol++;
            end
            if (frame_err) err_cnt++;
            if (start && frame_err) viol++;
            last_frame = pack_inputs();
            prev_start = start;
        end
    end

    // Stream under construction and the clk cycle of each bit's sclk rising edge.
    bit          fs_q[$];
    bit          sd_q[$];
    int unsigned rise_q[$];

    task automatic add_frame(input samples_t s, input int pad_mode, input int fs_len);
        for (int k = 0; k < N_CH; k++)
            for (int b = 0; b < SLOT_BITS; b++) begin
                fs_q.push_back(k == 0 && b < fs_len);
                if (b < SAMPLE_BITS) sd_q.push_back(s[k][SAMPLE_BITS-1-b]);
                else if (pad_mode == 0) sd_q.push_back(1'b0);
                else if (pad_mode == 1) sd_q.push_back(1'b1);
                else sd_q.push_back(1'($urandom));
            end
    endtask

    task automatic add_idle(input int n);
        for (int i = 0; i < n; i++) begin
            fs_q.push_back(1'b0);
            sd_q.push_back(1'($urandom));
        end
    endtask

    function automatic samples_t rand_samples();
        samples_t s;
        for (int k = 0; k < N_CH; k++) s[k] = 24'($urandom);
        return s;
    endfunction

    // Called just after a posedge; returns just after a posedge.
    task automatic drive_bit(input bit fs, input bit sd);
        sclk_in = 1'b0;
        fs_in   = fs;
        sd_in   = sd;
        repeat (BIT_CLKS / 2) @(posedge clk);
        #1;
        sclk_in = 1'b1;
        rise_q.push_back(cyc);
        repeat (BIT_CLKS / 2) @(posedge clk);
        #1;
    endtask

    function automatic logic [WORD_W-1:0] ref_word(input logic [SAMPLE_BITS-1:0] s);
        longint v;
        v = longint'(s);
        if (s[SAMPLE_BITS-1]) v = v - (longint'(1) <<< SAMPLE_BITS);
        v = v * (longint'(1) <<< FRAC_SHIFT);
        return v[WORD_W-1:0];
    endfunction

    // Drives the queued stream, then compares the DUT against the frame rules applied to it.
    task automatic run_stream(input string name, output int base_pub);
        frame_t exp_f[$];
        int     exp_idx[$];
        int     exp_err = 0;
        int     base_err, base_viol, n_got, n_chk;
        bit     prev_fs = 1'b0;
        bit     collecting = 1'b0;
        int     sp = 0;

        base_pub  = pub_q.size();
        base_err  = err_cnt;
        base_viol = viol;
        rise_q.delete();
        foreach (fs_q[i]) drive_bit(fs_q[i], sd_q[i]);
        repeat (BIT_CLKS) @(posedge clk);
        #1;

        for (int i = 0; i < fs_q.size(); i++) begin
            bit mk = fs_q[i] && !prev_fs;
            prev_fs = fs_q[i];
            if (mk) begin
                if (collecting) exp_err++;
                collecting = 1'b1;
                sp = i;
            end else if (collecting && i == sp + FRAME_BITS - 1) begin
                frame_t f;
                for (int k = 0; k < N_CH; k++) begin
                    logic [SAMPLE_BITS-1:0] s = '0;
                    for (int b = 0; b < SAMPLE_BITS; b++) s = {s[SAMPLE_BITS-2:0], sd_q[sp + k*SLOT_BITS + b]};
                    f[k] = ref_word(s);
                end
                exp_f.push_back(f);
                exp_idx.push_back(i);
                collecting = 1'b0;
            end
        end

        n_got = pub_q.size() - base_pub;
        check({name, "_starts"}, 64'(n_got), 64'(exp_f.size()));
        check({name, "_errs"}, 64'(err_cnt - base_err), 64'(exp_err));
        check({name, "_hold"}, 64'(viol - base_viol), 64'd0);
        n_chk = (n_got < exp_f.size()) ? n_got : exp_f.size();
        for (int j = 0; j < n_chk; j++) begin
            check($sformatf("%s_f%0d_lat", name, j), 64'(pubcyc_q[base_pub+j] - rise_q[exp_idx[j]]), 64'd4);
            for (int k = 0; k < N_CH; k++)
                check($sformatf("%s_f%0d_s%0d", name, j, k), 64'(pub_q[base_pub+j][k]), 64'(exp_f[j][k]));
        end
        fs_q.delete();
        sd_q.delete();
    endtask

    initial begin
        samples_t s;
        int       b;
        logic [SAMPLE_BITS-1:0] base;

        reset_n = 1'b0;
        sclk_in = 1'b0;
        fs_in   = 1'b0;
        sd_in   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_start", 64'(start), 64'd0);
        check("rst_frame_err", 64'(frame_err), 64'd0);
        check("rst_inputs_nonzero", 64'(pack_inputs() != '0), 64'd0);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // One aligned frame, slot k = k+1.
        for (int k = 0; k < N_CH; k++) s[k] = 24'(k + 1);
        add_frame(s, 2, 1);
        add_idle(8);
        run_stream("aligned", b);
        check("aligned_in0", 64'(inputs[0]), 64'h000000400);
        check("aligned_in7", 64'(inputs[7]), 64'h000002000);

        // Sign and extremes, pad bits all ones.
        s = rand_samples();
        s[0] = 24'h800000;
        s[1] = 24'h7FFFFF;
        s[2] = 24'hFFFFFF;
        add_frame(s, 1, 1);
        add_idle(8);
        run_stream("extreme", b);
        check("extreme_in0", 64'(inputs[0]), 64'hE00000000);
        check("extreme_in1", 64'(inputs[1]), 64'h1FFFFFC00);
        check("extreme_in2", 64'(inputs[2]), 64'hFFFFFFC00);

        // Ten back-to-back frames, slot 0 stepping by 0x100.
        base = 24'($urandom);
        for (int f = 0; f < 10; f++) begin
            s = rand_samples();
            s[0] = base + 24'(f * 'h100);
            add_frame(s, 2, 1);
        end
        add_idle(8);
        run_stream("b2b", b);
        for (int j = 1; j < 10; j++)
            if (b + j < pubcyc_q.size())
                check($sformatf("b2b_spacing%0d", j), 64'(pubcyc_q[b+j] - pubcyc_q[b+j-1]),
                      64'(FRAME_BITS * BIT_CLKS));

        // Marker at slot 3 bit 5 aborts the frame and starts a new one.
        add_frame(rand_samples(), 2, 1);
        repeat (FRAME_BITS - (3 * SLOT_BITS + 5)) begin
            void'(fs_q.pop_back());
            void'(sd_q.pop_back());
        end
        add_frame(rand_samples(), 2, 1);
        add_idle(8);
        run_stream("misalign", b);

        // Stream joined mid-frame: 100 bits with no marker first.
        add_idle(100);
        add_frame(rand_samples(), 2, 1);
        add_idle(8);
        run_stream("midjoin", b);

        // Reset pulse during slot 5 after a published frame.
        add_frame(rand_samples(), 2, 1);
        add_frame(rand_samples(), 2, 1);
        repeat (FRAME_BITS - (5 * SLOT_BITS + 10)) begin
            void'(fs_q.pop_back());
            void'(sd_q.pop_back());
        end
        run_stream("rst_a", b);
        reset_n = 1'b0;
        #1;
        check("rst_mid_inputs_nonzero", 64'(pack_inputs() != '0), 64'd0);
        check("rst_mid_start", 64'(start), 64'd0);
        check("rst_mid_frame_err", 64'(frame_err), 64'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        add_idle(FRAME_BITS - (5 * SLOT_BITS + 10));
        add_frame(rand_samples(), 2, 1);
        add_idle(8);
        run_stream("rst_b", b);

        // Random frames with random gaps and fs held high for 1..3 bits.
        for (int f = 0; f < 4; f++) begin
            add_idle($urandom_range(0, 5));
            add_frame(rand_samples(), 2, $urandom_range(1, 3));
        end
        add_idle(8);
        run_stream("random", b);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
